write_c_select_pipe: RTL and testbench
======================================

Name: write_c_select_pipe

Overview:
- Parametrised, registered successor to the register-file write-data source mux.
- Selects one of NUM_CH WIDTH-bit write-back sources and registers the result behind a valid/ready handshake.
- A 2-entry skid buffer lets the write-back stage stall without a combinational ready path back into execute.
- Flags out-of-range selects with a sticky error and keeps a wrapping count of delivered transfers for debug.

Parameters:
WIDTH, 8, data width of each source and of dat_out
NUM_CH, 4, number of selectable sources (2..16; need not be a power of 2)
SEL_W, $clog2(NUM_CH), select width (derived; do not override)
CNT_W, 16, width of the transfer counter

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
in_valid  input  1  upstream has a select/choices pair
in_ready  output  1  block can accept this cycle
select  input  SEL_W  source index
choices  input  NUM_CH*WIDTH  flattened sources; channel k at bits [k*WIDTH +: WIDTH]
out_valid  output  1  dat_out/out_sel hold a valid item
out_ready  input  1  downstream consumes when out_valid is high
dat_out  output  WIDTH  selected data
out_sel  output  SEL_W  select value that produced dat_out
sel_err  output  1  sticky: an out-of-range select was accepted
clr_err  input  1  clears sel_err
xfer_cnt  output  CNT_W  count of completed output transfers (out_valid && out_ready)

Behaviour:
- Reset (reset_n low at posedge): state EMPTY, out_valid=0, in_ready=1 on the next cycle, dat_out=0, out_sel=0, sel_err=0, xfer_cnt=0, skid register=0.
- Accept condition: in_valid && in_ready.
- Transfer condition: out_valid && out_ready.
- Selected value:
  - select < NUM_CH: choices channel select.
  - select >= NUM_CH: all-zero data; out_sel carries the raw select.
- Latency is 1 cycle: an item accepted at edge N appears on dat_out with out_valid high after edge N when the buffer is empty.
- State machine, held in main register plus skid register:
  - EMPTY:
    - accept -> ONE; main <= item.
  - ONE:
    - accept and out_ready -> ONE; main <= new item.
    - accept and !out_ready -> FULL; skid <= new item; main unchanged.
    - !accept and out_ready -> EMPTY.
    - otherwise stay in ONE; main holds.
  - FULL:
    - out_ready -> ONE; main <= skid.
    - otherwise stay in FULL.
- in_ready = (state != FULL), driven from registered state only. No combinational path from out_ready or in_valid to in_ready.
- Ordering is strictly FIFO. No item is dropped or duplicated.
- While out_valid is high and out_ready is low, dat_out and out_sel are stable.
- in_valid while in_ready is low is ignored. Upstream must hold its item.
- sel_err:
  - set at the edge where an item with select >= NUM_CH is accepted.
  - cleared by clr_err.
  - set and clear in the same cycle: set wins.
- xfer_cnt:
  - increments by 1 on each transfer.
  - wraps from 2^CNT_W-1 to 0 without any flag.
- Reset asserted mid-operation: all buffered items are discarded and outputs take their reset values at that edge. There is no partial drain.
- choices is sampled only at accept. Later changes to choices do not affect buffered items.

Decomposition:
- Package write_c_pkg: state enum {EMPTY, ONE, FULL}; struct item_t {data[WIDTH], sel[SEL_W]} as a parametrised typedef or macro; default-width constants.
- Sub-module wb_skid_reg:
  - generic 2-entry skid buffer over item_t, containing the state machine and handshake.
  - The top level keeps the select decode, the out-of-range zeroing, sel_err and xfer_cnt.

Test Plan:
- Reset check: hold reset_n low 2 cycles with in_valid=1 -> out_valid=0, dat_out=0, sel_err=0, xfer_cnt=0. After release, in_ready=1.
- Streaming: out_ready=1; send select=0,1,2,3 with choices {0x11,0x22,0x33,0x44} on consecutive cycles -> dat_out sequence 0x11,0x22,0x33,0x44, one cycle after each accept; xfer_cnt=4.
- Backpressure: out_ready=0; send select=2 (0xA5) then select=1 (0x5A) -> in_ready drops to 0 after the 2nd accept and dat_out holds 0xA5. Raise out_ready -> 0xA5 then 0x5A delivered in order; in_ready returns to 1.
- Out-of-range: NUM_CH=3; send select=3 -> dat_out=0x00, out_sel=3, sel_err=1. Pulse clr_err alone -> sel_err=0. clr_err together with another select=3 accept -> sel_err stays 1.
- Counter wrap: CNT_W=4; perform 17 transfers -> xfer_cnt reads 1.
- Mid-operation reset: bring the buffer to FULL, then assert reset_n low for 1 cycle -> out_valid=0 and in_ready=1 after release. No stale item is ever delivered.

Source files
------------

// File: rtl/write_c_select_pipe_pkg.sv
// Shared types and defaults for the registered write-data select pipe.
`ifndef WRITE_C_ITEM_T
`define WRITE_C_ITEM_T(W, S) struct packed { logic [(W)-1:0] data; logic [(S)-1:0] sel; }
`endif

package write_c_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_NUM_CH = 4;
  localparam int unsigned DEF_CNT_W  = 16;

endpackage

// File: rtl/write_c_select_pipe_wb_skid_reg.sv
// Two-entry skid buffer: main register drives the output, skid catches one
// item while downstream stalls so in_ready depends only on registered state.
module wb_skid_reg
  import write_c_pkg::*;
#(
  parameter type item_t = logic [7:0]
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  in_valid,
  output logic  in_ready,
  input  item_t in_item,
  output logic  out_valid,
  input  logic  out_ready,
  output item_t out_item
);

  state_t state;
  item_t  main_q;
  item_t  skid_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            state  <= ONE;
            main_q <= in_item;
          end
        end
        ONE: begin
          if (in_valid) begin
            if (out_ready) begin
              main_q <= in_item;
            end else begin
              skid_q <= in_item;
              state  <= FULL;
            end
          end else if (out_ready) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_ready) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_item  = main_q;

endmodule

// File: rtl/write_c_select_pipe.sv
// Registered write-back source select with skid-buffered handshake, sticky
// out-of-range flag and a wrapping transfer counter.
module write_c_select_pipe
  import write_c_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned SEL_W  = $clog2(NUM_CH),
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        select,
  input  logic [NUM_CH*WIDTH-1:0] choices,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        dat_out,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    sel_err,
  input  logic                    clr_err,
  output logic [CNT_W-1:0]        xfer_cnt
);

  typedef `WRITE_C_ITEM_T(WIDTH, SEL_W) item_t;

  item_t            in_item;
  item_t            out_item;
  logic [WIDTH-1:0] sel_data;
  logic             in_range;
  logic             accept;
  logic             xfer;

  // Loop decode keeps out-of-range selects at zero without indexing past choices.
  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (32'(select) == k) begin
        sel_data = choices[k*WIDTH +: WIDTH];
      end
    end
  end

  assign in_range     = (32'(select) < NUM_CH);
  assign in_item.data = sel_data;
  assign in_item.sel  = select;

  assign accept = in_valid && in_ready;
  assign xfer   = out_valid && out_ready;

  wb_skid_reg #(
    .item_t(item_t)
  ) u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_item  (in_item),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_item (out_item)
  );

  assign dat_out = out_item.data;
  assign out_sel = out_item.sel;

  // Setting takes priority over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel_err <= 1'b0;
    end else if (accept && !in_range) begin
      sel_err <= 1'b1;
    end else if (clr_err) begin
      sel_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      xfer_cnt <= '0;
    end else if (xfer) begin
      xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_write_c_select_pipe.sv
// Scoreboard bench for write_c_select_pipe (NUM_CH=3, CNT_W=4).
module tb_write_c_select_pipe;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned NUM_CH = 3;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CNT_W  = 4;

  logic                    clk;
  logic                    reset_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        select;
  logic [NUM_CH*WIDTH-1:0] choices;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        dat_out;
  logic [SEL_W-1:0]        out_sel;
  logic                    sel_err;
  logic                    clr_err;
  logic [CNT_W-1:0]        xfer_cnt;

  write_c_select_pipe #(
    .WIDTH (WIDTH),
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .select   (select),
    .choices  (choices),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dat_out  (dat_out),
    .out_sel  (out_sel),
    .sel_err  (sel_err),
    .clr_err  (clr_err),
    .xfer_cnt (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [SEL_W-1:0] s;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   m_cnt    = 0;
  bit   m_err    = 1'b0;
  bit   fresh    = 1'b1;
  bit   armed    = 1'b0;
  bit   rnd_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] pick(input logic [SEL_W-1:0] s, input logic [NUM_CH*WIDTH-1:0] c);
    int i;
    i = int'(s);
    if (i >= int'(NUM_CH)) return '0;
    return c[i*WIDTH +: WIDTH];
  endfunction

  // Monitor: compare against model at negedge, then advance model for the next edge.
  always @(negedge clk) begin
    bit   acc;
    bit   xf;
    exp_t e;
    if (!reset_n) begin
      q.delete();
      m_err = 1'b0;
      m_cnt = 0;
      fresh = 1'b1;
      armed = 1'b1;
    end else if (armed) begin
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      check("in_ready", 32'(in_ready), 32'(q.size() < 2));
      if (q.size() != 0) begin
        check("dat_out", 32'(dat_out), 32'(q[0].d));
        check("out_sel", 32'(out_sel), 32'(q[0].s));
      end else if (fresh) begin
        check("dat_out_rst", 32'(dat_out), 32'd0);
        check("out_sel_rst", 32'(out_sel), 32'd0);
      end
      check("sel_err", 32'(sel_err), 32'(m_err));
      check("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt % 16));
      acc = in_valid && (q.size() < 2);
      xf  = out_ready && (q.size() != 0);
      if (xf) begin
        void'(q.pop_front());
        m_cnt++;
      end
      if (acc) begin
        e.d = pick(select, choices);
        e.s = select;
        q.push_back(e);
        fresh = 1'b0;
      end
      if (acc && int'(select) >= int'(NUM_CH)) m_err = 1'b1;
      else if (clr_err) m_err = 1'b0;
    end
  end

  task automatic send(input logic [SEL_W-1:0] s, input logic [NUM_CH*WIDTH-1:0] c);
    bit ok;
    int n;
    in_valid = 1'b1;
    select   = s;
    choices  = c;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b1;
    select    = '0;
    choices   = 24'h332211;
    out_ready = 1'b0;
    clr_err   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n  = 1'b1;
    in_valid = 1'b0;
    idle(2);

    // Streaming, including an out-of-range select.
    out_ready = 1'b1;
    send(2'd0, 24'h332211);
    send(2'd1, 24'h332211);
    send(2'd2, 24'h332211);
    send(2'd3, 24'h332211);
    drain();
    check("stream_cnt", 32'(xfer_cnt), 32'd4);

    // Sticky error: lone clear, then clear colliding with a new set.
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    idle(1);
    clr_err = 1'b1;
    send(2'd3, 24'hFFFFFF);
    clr_err = 1'b0;
    drain();
    check("err_sticky", 32'(sel_err), 32'd1);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;

    // Backpressure into FULL, hold, then release.
    out_ready = 1'b0;
    send(2'd2, 24'hA55A00);
    send(2'd1, 24'hA55A00);
    choices = 24'h000000;
    idle(4);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_hold", 32'(dat_out), 32'hA5);
    out_ready = 1'b1;
    drain();

    // Randomized traffic with random backpressure and clears.
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          send(2'($urandom_range(0, 3)), 24'($urandom));
          if ($urandom_range(0, 3) == 0) begin
            choices = 24'($urandom);
            idle($urandom_range(1, 3));
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
          clr_err   = ($urandom_range(0, 15) == 0);
        end
      end
    join
    out_ready = 1'b1;
    clr_err   = 1'b0;
    drain();

    // Reset while FULL: buffered items must vanish.
    out_ready = 1'b0;
    send(2'd0, 24'h0000C3);
    send(2'd1, 24'h003C00);
    idle(1);
    reset_n = 1'b0;
    idle(1);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    idle(5);
    check("rst_mid_cnt", 32'(xfer_cnt), 32'd0);

    // Counter wrap: 17 transfers on a 4-bit counter.
    for (int i = 0; i < 17; i++) send(2'(i % 3), 24'($urandom));
    drain();
    check("cnt_wrap", 32'(xfer_cnt), 32'd1);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
